// File: rtl/stdp_pkg.sv
// Shared types for the STDP update sequencer: FSM states and per-synapse actions.
package stdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2
    } stdp_act_t;

endpackage

// File: rtl/stdp_rule_decode.sv
// Combinational STDP rule decode for one synapse: capture, minus and backoff rules.
module stdp_rule_decode
    import stdp_pkg::*;
(
    input  logic      in_bit,
    input  logic      out_bit,
    input  logic      cap_en,
    input  logic      min_en,
    input  logic      bkf_en,
    output stdp_act_t act
);

    // The three rules are mutually exclusive on (in_bit, out_bit), so the order is only for clarity.
    always_comb begin
        act = ACT_NONE;
        if (in_bit && out_bit && cap_en) begin
            act = ACT_INC;
        end else if (in_bit && !out_bit && min_en) begin
            act = ACT_DEC;
        end else if (!in_bit && out_bit && bkf_en) begin
            act = ACT_DEC;
        end else begin
            act = ACT_NONE;
        end
    end

endmodule

// File: rtl/stdp_update_sequencer.sv
// Walks one column's synapses one per cycle after a start strobe and emits registered
// inc/dec pulses to the weight counters from a snapshot of the spike state.
module stdp_update_sequencer
    import stdp_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in_spk,
    input  logic         out_spk,
    input  logic         cap_en,
    input  logic         min_en,
    input  logic         bkf_en,
    output logic [N-1:0] inc,
    output logic [N-1:0] dec,
    output logic         busy,
    output logic         done
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic             capture_s;

    logic [N-1:0]     in_spk_r;
    logic             out_spk_r;
    logic             cap_r;
    logic             min_r;
    logic             bkf_r;

    stdp_act_t        act_s;
    logic [N-1:0]     inc_s;
    logic [N-1:0]     dec_s;

    logic [N-1:0]     inc_r;
    logic [N-1:0]     dec_r;
    logic             busy_r;
    logic             done_r;

    // One shared decoder looks at whichever synapse the index currently points to.
    stdp_rule_decode u_decode (
        .in_bit  (in_spk_r[idx_r]),
        .out_bit (out_spk_r),
        .cap_en  (cap_r),
        .min_en  (min_r),
        .bkf_en  (bkf_r),
        .act     (act_s)
    );

    // Next-state and index logic; start is only looked at while idle.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_SCAN;
                    idx_s     = '0;
                    capture_s = 1'b1;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == IDX_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s   = idx_r + IDX_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // One-hot pulse for the synapse under scan; nothing outside SCAN.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        if (state_r == ST_SCAN) begin
            case (act_s)
                ACT_INC: inc_s[idx_r] = 1'b1;
                ACT_DEC: dec_s[idx_r] = 1'b1;
                default: begin
                    inc_s = '0;
                    dec_s = '0;
                end
            endcase
        end else begin
            inc_s = '0;
            dec_s = '0;
        end
    end

    // State, index, snapshot and output registers; reset aborts any pass in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            in_spk_r  <= '0;
            out_spk_r <= 1'b0;
            cap_r     <= 1'b0;
            min_r     <= 1'b0;
            bkf_r     <= 1'b0;
            inc_r     <= '0;
            dec_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            if (capture_s) begin
                in_spk_r  <= in_spk;
                out_spk_r <= out_spk;
                cap_r     <= cap_en;
                min_r     <= min_en;
                bkf_r     <= bkf_en;
            end
            inc_r  <= inc_s;
            dec_r  <= dec_s;
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
        end
    end

    assign inc  = inc_r;
    assign dec  = dec_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
